// File: rtl/calc_sequencer.sv
// calc_sequencer: front-end controller for the four-digit calculator.
// Edge-detects the push-buttons, collects four BCD operand digits, drives one
// operation line of the combinational datapath for a settle window and then
// registers the datapath result for the 7-segment display stage.
// Every output is a register; the datapath result is passed through untouched.

module calc_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_sw,
    input  logic       btn_enter,
    input  logic [4:0] btn_op,
    input  logic       btn_clr,
    output logic [3:0] dp_in0,
    output logic [3:0] dp_in1,
    output logic [3:0] dp_in2,
    output logic [3:0] dp_in3,
    output logic [4:0] dp_op,
    input  logic [3:0] dp_out0,
    input  logic [3:0] dp_out1,
    input  logic [3:0] dp_out2,
    input  logic [3:0] dp_out3,
    input  logic       dp_dc,
    output logic [3:0] disp0,
    output logic [3:0] disp1,
    output logic [3:0] disp2,
    output logic [3:0] disp3,
    output logic [1:0] digit_idx,
    output logic       result_dc,
    output logic       busy,
    output logic       entry_err
);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_READY   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SHOW    = 3'd4
    } state_t;

    // Last value of the settle counter before moving on to CAPTURE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    // A switch setting is a usable operand digit only if it is valid BCD.
    function automatic logic digit_ok(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // Keep only the lowest set bit, so add beats sub beats mul and so on.
    function automatic logic [4:0] pick_op(input logic [4:0] e);
        return e & (~e + 5'd1);
    endfunction

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [4:0] op_r, op_s;
    logic [3:0] in0_r, in1_r, in2_r, in3_r;
    logic [3:0] in0_s, in1_s, in2_s, in3_s;
    logic [3:0] disp0_r, disp1_r, disp2_r, disp3_r;
    logic [3:0] disp0_s, disp1_s, disp2_s, disp3_s;
    logic [1:0] idx_r, idx_s;
    logic       dc_r, dc_s;
    logic       busy_r, busy_s;
    logic       err_r, err_s;

    // Previous button levels; loaded with 1 in reset so a held button is quiet.
    logic       prev_enter_r;
    logic [4:0] prev_op_r;
    logic       prev_clr_r;

    logic       enter_edge_s;
    logic [4:0] op_edge_s;
    logic       clr_edge_s;

    assign enter_edge_s = btn_enter & ~prev_enter_r;
    assign op_edge_s    = btn_op & ~prev_op_r;
    assign clr_edge_s   = btn_clr & ~prev_clr_r;

    // Next-state and next-register computation; clear overrides every state.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        in0_s   = in0_r;
        in1_s   = in1_r;
        in2_s   = in2_r;
        in3_s   = in3_r;
        disp0_s = disp0_r;
        disp1_s = disp1_r;
        disp2_s = disp2_r;
        disp3_s = disp3_r;
        idx_s   = idx_r;
        dc_s    = dc_r;
        err_s   = 1'b0;

        if (clr_edge_s) begin
            state_s = ST_ENTRY;
            cnt_s   = 4'd0;
            op_s    = 5'd0;
            in0_s   = 4'd0;
            in1_s   = 4'd0;
            in2_s   = 4'd0;
            in3_s   = 4'd0;
            disp0_s = 4'd0;
            disp1_s = 4'd0;
            disp2_s = 4'd0;
            disp3_s = 4'd0;
            idx_s   = 2'd0;
            dc_s    = 1'b1;
        end else begin
            case (state_r)
                ST_ENTRY: begin
                    if (enter_edge_s) begin
                        if (digit_ok(digit_sw)) begin
                            // Slot 0 is the tens digit of operand 1 (in3).
                            case (idx_r)
                                2'd0:    in3_s = digit_sw;
                                2'd1:    in2_s = digit_sw;
                                2'd2:    in1_s = digit_sw;
                                2'd3:    in0_s = digit_sw;
                                default: in3_s = in3_r;
                            endcase
                            disp3_s = in3_s;
                            disp2_s = in2_s;
                            disp1_s = in1_s;
                            disp0_s = in0_s;
                            if (idx_r == 2'd3) begin
                                idx_s   = 2'd0;
                                state_s = ST_READY;
                            end else begin
                                idx_s = idx_r + 2'd1;
                            end
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_ENTRY;
                    end
                end
                ST_READY: begin
                    if (op_edge_s != 5'd0) begin
                        op_s    = pick_op(op_edge_s);
                        cnt_s   = 4'd0;
                        state_s = ST_EXEC;
                    end else begin
                        state_s = ST_READY;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_s = ST_CAPTURE;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    disp0_s = dp_out0;
                    disp1_s = dp_out1;
                    disp2_s = dp_out2;
                    disp3_s = dp_out3;
                    dc_s    = dp_dc;
                    op_s    = 5'd0;
                    state_s = ST_SHOW;
                end
                ST_SHOW: begin
                    if (op_edge_s != 5'd0) begin
                        op_s    = pick_op(op_edge_s);
                        cnt_s   = 4'd0;
                        state_s = ST_EXEC;
                    end else if (enter_edge_s) begin
                        // A fresh entry restarts from an all-zero operand set.
                        in3_s   = digit_ok(digit_sw) ? digit_sw : 4'd0;
                        in2_s   = 4'd0;
                        in1_s   = 4'd0;
                        in0_s   = 4'd0;
                        disp3_s = in3_s;
                        disp2_s = 4'd0;
                        disp1_s = 4'd0;
                        disp0_s = 4'd0;
                        idx_s   = digit_ok(digit_sw) ? 2'd1 : 2'd0;
                        err_s   = ~digit_ok(digit_sw);
                        state_s = ST_ENTRY;
                    end else begin
                        state_s = ST_SHOW;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet entry state.
                    state_s = ST_ENTRY;
                    op_s    = 5'd0;
                    cnt_s   = 4'd0;
                    idx_s   = 2'd0;
                end
            endcase
        end

        busy_s = (state_s == ST_EXEC) || (state_s == ST_CAPTURE);
    end

    // State, datapath-facing and display registers, plus button history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_ENTRY;
            cnt_r        <= 4'd0;
            op_r         <= 5'd0;
            in0_r        <= 4'd0;
            in1_r        <= 4'd0;
            in2_r        <= 4'd0;
            in3_r        <= 4'd0;
            disp0_r      <= 4'd0;
            disp1_r      <= 4'd0;
            disp2_r      <= 4'd0;
            disp3_r      <= 4'd0;
            idx_r        <= 2'd0;
            dc_r         <= 1'b1;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            prev_enter_r <= 1'b1;
            prev_op_r    <= 5'b11111;
            prev_clr_r   <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            op_r         <= op_s;
            in0_r        <= in0_s;
            in1_r        <= in1_s;
            in2_r        <= in2_s;
            in3_r        <= in3_s;
            disp0_r      <= disp0_s;
            disp1_r      <= disp1_s;
            disp2_r      <= disp2_s;
            disp3_r      <= disp3_s;
            idx_r        <= idx_s;
            dc_r         <= dc_s;
            busy_r       <= busy_s;
            err_r        <= err_s;
            prev_enter_r <= btn_enter;
            prev_op_r    <= btn_op;
            prev_clr_r   <= btn_clr;
        end
    end

    assign dp_in0    = in0_r;
    assign dp_in1    = in1_r;
    assign dp_in2    = in2_r;
    assign dp_in3    = in3_r;
    assign dp_op     = op_r;
    assign disp0     = disp0_r;
    assign disp1     = disp1_r;
    assign disp2     = disp2_r;
    assign disp3     = disp3_r;
    assign digit_idx = idx_r;
    assign result_dc = dc_r;
    assign busy      = busy_r;
    assign entry_err = err_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: two instances (settle 1 and settle 4) share the
// button inputs; each sees its own behavioural datapath. A high-level model
// (operand list, digit count, phase) predicts the display after each action.

module tb_calc_sequencer;

    localparam int PH_ENTRY = 0;
    localparam int PH_READY = 1;
    localparam int PH_SHOW  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_sw;
    logic       btn_enter;
    logic [4:0] btn_op;
    logic       btn_clr;

    logic [3:0]  in0_a[2], in1_a[2], in2_a[2], in3_a[2];
    logic [3:0]  d0_a[2], d1_a[2], d2_a[2], d3_a[2];
    logic [4:0]  op_a[2];
    logic [15:0] out_a[2];
    logic        dc_a[2];
    logic [1:0]  idx_a[2];
    logic        rdc_a[2], busy_a[2], err_a[2];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ops[4];
    int          m_cnt;
    int          m_phase;
    logic [15:0] m_res;
    logic        m_dc;
    bit          m_dc_known;

    always #5 clk = ~clk;

    function automatic logic [15:0] to_dig(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Behavioural stand-in for the combinational arithmetic datapath.
    function automatic logic [15:0] calc(input int a, input int b, input logic [4:0] op);
        logic [15:0] c;
        case (op)
            5'b00001: c = to_dig(a + b);
            5'b00010: c = (a >= b) ? to_dig(a - b)
                                   : {4'd0, 4'd10, 4'((b - a) / 10), 4'((b - a) % 10)};
            5'b00100: c = to_dig(a * b);
            5'b01000: c = (b == 0) ? {4'd13, 4'd12, 4'd11, 4'd11} : to_dig(a / b);
            5'b10000: c = to_dig(a * 100 + b);
            default:  c = 16'd0;
        endcase
        return c;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign out_a[g] = calc(10 * int'(in3_a[g]) + int'(in2_a[g]),
                               10 * int'(in1_a[g]) + int'(in0_a[g]), op_a[g]);
        assign dc_a[g]  = (op_a[g] == 5'd0);
        calc_sequencer #(.SETTLE_CYCLES(g == 0 ? 1 : 4)) dut (
            .clk(clk), .rst(rst), .digit_sw(digit_sw), .btn_enter(btn_enter),
            .btn_op(btn_op), .btn_clr(btn_clr),
            .dp_in0(in0_a[g]), .dp_in1(in1_a[g]), .dp_in2(in2_a[g]), .dp_in3(in3_a[g]),
            .dp_op(op_a[g]),
            .dp_out0(out_a[g][3:0]), .dp_out1(out_a[g][7:4]),
            .dp_out2(out_a[g][11:8]), .dp_out3(out_a[g][15:12]),
            .dp_dc(dc_a[g]),
            .disp0(d0_a[g]), .disp1(d1_a[g]), .disp2(d2_a[g]), .disp3(d3_a[g]),
            .digit_idx(idx_a[g]), .result_dc(rdc_a[g]), .busy(busy_a[g]),
            .entry_err(err_a[g])
        );
    end

    function automatic int settle_of(input int g);
        return (g == 0) ? 1 : 4;
    endfunction

    function automatic logic [15:0] disp_of(input int g);
        return {d3_a[g], d2_a[g], d1_a[g], d0_a[g]};
    endfunction

    function automatic logic [15:0] ins_of(input int g);
        return {in3_a[g], in2_a[g], in1_a[g], in0_a[g]};
    endfunction

    function automatic logic [15:0] exp_ops();
        return {4'(m_ops[0]), 4'(m_ops[1]), 4'(m_ops[2]), 4'(m_ops[3])};
    endfunction

    function automatic logic [15:0] exp_disp();
        return (m_phase == PH_SHOW) ? m_res : exp_ops();
    endfunction

    function automatic logic [4:0] lowest(input logic [4:0] op);
        for (int k = 0; k < 5; k++) begin
            if (op[k]) return 5'(1 << k);
        end
        return 5'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int k = 0; k < 4; k++) m_ops[k] = 0;
        m_cnt = 0;
        m_phase = PH_ENTRY;
        m_res = 16'd0;
        m_dc = 1'b1;
        m_dc_known = 1'b1;
    endtask

    // Apply one button action for a single cycle, update the model, then let
    // both instances settle. err_seen holds entry_err one cycle after the edge.
    task automatic press(input logic en, input logic [4:0] op, input logic clr,
                         input logic [3:0] d, output logic [1:0] err_seen,
                         output logic exp_err);
        logic taken;
        taken = !clr && (op != 5'd0) && (m_phase != PH_ENTRY);
        exp_err = 1'b0;
        digit_sw = d; btn_enter = en; btn_op = op; btn_clr = clr;
        tick();
        err_seen = {err_a[1], err_a[0]};
        btn_enter = 1'b0; btn_op = 5'd0; btn_clr = 1'b0;
        if (clr) begin
            m_clear();
        end else if (taken) begin
            m_res = calc(m_ops[0] * 10 + m_ops[1], m_ops[2] * 10 + m_ops[3], lowest(op));
            m_dc = 1'b0;
            m_dc_known = 1'b1;
            m_phase = PH_SHOW;
        end else if (en && m_phase != PH_READY) begin
            if (m_phase == PH_SHOW) begin
                for (int k = 0; k < 4; k++) m_ops[k] = 0;
                m_cnt = 0;
                m_phase = PH_ENTRY;
                m_dc_known = 1'b0;
            end
            if (d <= 4'd9) begin
                m_ops[m_cnt] = int'(d);
                m_cnt++;
                if (m_cnt == 4) begin
                    m_cnt = 0;
                    m_phase = PH_READY;
                end
            end else begin
                exp_err = 1'b1;
            end
        end
        repeat (6) tick();
    endtask

    task automatic enter4(input int a, input int b, input int c, input int e);
        logic [1:0] es;
        logic       ee;
        press(1'b1, 5'd0, 1'b0, 4'(a), es, ee);
        press(1'b1, 5'd0, 1'b0, 4'(b), es, ee);
        press(1'b1, 5'd0, 1'b0, 4'(c), es, ee);
        press(1'b1, 5'd0, 1'b0, 4'(e), es, ee);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_enter = 1'b1; btn_op = 5'b11111; btn_clr = 1'b1; digit_sw = 4'd5;
        tick(); tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (disp_of(g) !== 16'd0 || ins_of(g) !== 16'd0) begin
                errors++;
                $display("FAIL reset_data inst%0d: disp=%h in=%h expected 0000", g, disp_of(g), ins_of(g));
            end
            checks++;
            if ({op_a[g], idx_a[g], rdc_a[g], busy_a[g], err_a[g]} !== {5'd0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: op=%b idx=%0d dc=%b busy=%b err=%b expected 00000 0 1 0 0",
                         g, op_a[g], idx_a[g], rdc_a[g], busy_a[g], err_a[g]);
            end
        end
        btn_enter = 1'b0; btn_op = 5'd0; btn_clr = 1'b0;
        tick();
        m_clear();
    endtask

    task automatic test_add_timing();
        enter4(1, 2, 3, 4);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (disp_of(g) !== 16'h1234 || idx_a[g] !== 2'd0) begin
                errors++;
                $display("FAIL add_entry inst%0d: disp=%h idx=%0d expected 1234 idx 0", g, disp_of(g), idx_a[g]);
            end
        end
        btn_op = 5'b00001;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 1) btn_op = 5'd0;
            for (int g = 0; g < 2; g++) begin
                bit act;
                act = (i <= settle_of(g) + 1);
                checks++;
                if (op_a[g] !== (act ? 5'b00001 : 5'b00000) || busy_a[g] !== act) begin
                    errors++;
                    $display("FAIL add_timing cyc%0d inst%0d: op=%b busy=%b expected active=%0d",
                             i, g, op_a[g], busy_a[g], act);
                end
                checks++;
                if (act && (disp_of(g) !== 16'h1234 || rdc_a[g] !== 1'b1)) begin
                    errors++;
                    $display("FAIL add_early cyc%0d inst%0d: disp=%h dc=%b expected 1234 1", i, g, disp_of(g), rdc_a[g]);
                end else if (!act && (disp_of(g) !== 16'h0046 || rdc_a[g] !== 1'b0)) begin
                    errors++;
                    $display("FAIL add_result cyc%0d inst%0d: disp=%h dc=%b expected 0046 0", i, g, disp_of(g), rdc_a[g]);
                end
            end
        end
        m_phase = PH_SHOW; m_res = 16'h0046; m_dc = 1'b0; m_dc_known = 1'b1;
    endtask

    task automatic test_sub_mul();
        logic [1:0] es;
        logic       ee;
        press(1'b0, 5'd0, 1'b1, 4'd0, es, ee);
        enter4(1, 2, 3, 4);
        press(1'b0, 5'b00010, 1'b0, 4'd0, es, ee);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (disp_of(g) !== 16'h0A22) begin
                errors++;
                $display("FAIL sub inst%0d: disp=%h expected 0a22", g, disp_of(g));
            end
        end
        enter4(9, 9, 9, 9);
        press(1'b0, 5'b00100, 1'b0, 4'd0, es, ee);
        press(1'b0, 5'b00100, 1'b0, 4'd0, es, ee);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (disp_of(g) !== 16'h9801 || rdc_a[g] !== 1'b0) begin
                errors++;
                $display("FAIL mul inst%0d: disp=%h dc=%b expected 9801 0", g, disp_of(g), rdc_a[g]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [1:0] es;
        logic       ee;
        enter4(3, 4, 0, 0);
        press(1'b0, 5'b01000, 1'b0, 4'd0, es, ee);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (disp_of(g) !== 16'hDCBB) begin
                errors++;
                $display("FAIL div0 inst%0d: disp=%h expected dcbb", g, disp_of(g));
            end
        end
    endtask

    task automatic test_entry_err_and_priority();
        logic [1:0] es;
        logic       ee;
        press(1'b0, 5'd0, 1'b1, 4'd0, es, ee);
        digit_sw = 4'd5; btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (d3_a[g] !== 4'd5 || in3_a[g] !== 4'd5 || idx_a[g] !== 2'd1) begin
                errors++;
                $display("FAIL enter_lat inst%0d: disp3=%0d in3=%0d idx=%0d expected 5 5 1", g, d3_a[g], in3_a[g], idx_a[g]);
            end
        end
        tick();
        digit_sw = 4'd12; btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (err_a[g] !== 1'b1 || idx_a[g] !== 2'd1) begin
                errors++;
                $display("FAIL err_pulse inst%0d: err=%b idx=%0d expected 1 1", g, err_a[g], idx_a[g]);
            end
        end
        tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (err_a[g] !== 1'b0 || idx_a[g] !== 2'd1 || disp_of(g) !== 16'h5000) begin
                errors++;
                $display("FAIL err_after inst%0d: err=%b idx=%0d disp=%h expected 0 1 5000", g, err_a[g], idx_a[g], disp_of(g));
            end
        end
        // A held enter button stores exactly one digit.
        digit_sw = 4'd6; btn_enter = 1'b1;
        repeat (4) tick();
        btn_enter = 1'b0;
        tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (idx_a[g] !== 2'd2 || disp_of(g) !== 16'h5600) begin
                errors++;
                $display("FAIL held inst%0d: idx=%0d disp=%h expected 2 5600", g, idx_a[g], disp_of(g));
            end
        end
        m_ops[0] = 5; m_ops[1] = 6; m_cnt = 2;
        press(1'b1, 5'd0, 1'b0, 4'd7, es, ee);
        press(1'b1, 5'd0, 1'b0, 4'd8, es, ee);
        btn_op = 5'b00101;
        tick();
        btn_op = 5'd0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (op_a[g] !== 5'b00001) begin
                errors++;
                $display("FAIL op_prio inst%0d: op=%b expected 00001", g, op_a[g]);
            end
        end
        repeat (6) tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (disp_of(g) !== 16'h0134) begin
                errors++;
                $display("FAIL op_prio_res inst%0d: disp=%h expected 0134", g, disp_of(g));
            end
        end
        m_phase = PH_SHOW; m_res = 16'h0134; m_dc = 1'b0; m_dc_known = 1'b1;
    endtask

    task automatic test_clear_exec();
        logic [1:0] es;
        logic       ee;
        press(1'b0, 5'd0, 1'b1, 4'd0, es, ee);
        enter4(1, 2, 3, 4);
        btn_op = 5'b00001;
        tick();
        btn_op = 5'd0; btn_clr = 1'b1;
        tick();
        btn_clr = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (op_a[g] !== 5'd0 || busy_a[g] !== 1'b0 || disp_of(g) !== 16'd0 || ins_of(g) !== 16'd0 ||
                idx_a[g] !== 2'd0 || rdc_a[g] !== 1'b1) begin
                errors++;
                $display("FAIL clr_exec inst%0d: op=%b busy=%b disp=%h in=%h idx=%0d dc=%b expected 0 0 0000 0000 0 1",
                         g, op_a[g], busy_a[g], disp_of(g), ins_of(g), idx_a[g], rdc_a[g]);
            end
        end
        repeat (6) tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (disp_of(g) !== 16'd0 || rdc_a[g] !== 1'b1 || op_a[g] !== 5'd0) begin
                errors++;
                $display("FAIL clr_nocap inst%0d: disp=%h dc=%b op=%b expected 0000 1 0", g, disp_of(g), rdc_a[g], op_a[g]);
            end
        end
        m_clear();
    endtask

    task automatic test_random();
        logic [1:0] es;
        logic       ee;
        for (int it = 0; it < 80; it++) begin
            int r;
            r = int'($urandom_range(0, 12));
            if (r <= 5)
                press(1'b1, 5'd0, 1'b0, 4'($urandom_range(0, 11)), es, ee);
            else if (r <= 9)
                press(1'b0, 5'($urandom_range(1, 31)), 1'b0, 4'd0, es, ee);
            else if (r <= 11)
                press(1'b1, 5'($urandom_range(1, 31)), 1'b0, 4'($urandom_range(0, 11)), es, ee);
            else
                press(1'b0, 5'd0, 1'b1, 4'd0, es, ee);
            for (int g = 0; g < 2; g++) begin
                checks++;
                if (es[g] !== ee) begin
                    errors++;
                    $display("FAIL rnd_err it%0d inst%0d: err=%b expected %b", it, g, es[g], ee);
                end
                checks++;
                if (disp_of(g) !== exp_disp() || ins_of(g) !== exp_ops()) begin
                    errors++;
                    $display("FAIL rnd_data it%0d inst%0d: disp=%h in=%h expected %h %h",
                             it, g, disp_of(g), ins_of(g), exp_disp(), exp_ops());
                end
                checks++;
                if (idx_a[g] !== 2'(m_cnt) || op_a[g] !== 5'd0 || busy_a[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_ctrl it%0d inst%0d: idx=%0d op=%b busy=%b expected %0d 00000 0",
                             it, g, idx_a[g], op_a[g], busy_a[g], m_cnt);
                end
                if (m_dc_known) begin
                    checks++;
                    if (rdc_a[g] !== m_dc) begin
                        errors++;
                        $display("FAIL rnd_dc it%0d inst%0d: dc=%b expected %b", it, g, rdc_a[g], m_dc);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; digit_sw = 4'd0; btn_enter = 1'b0; btn_op = 5'd0; btn_clr = 1'b0;
        m_clear();
        test_reset();
        test_add_timing();
        test_sub_mul();
        test_div_zero();
        test_entry_err_and_priority();
        test_clear_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
